pipe_flow_ctrl: RTL and testbench
=================================

Name: pipe_flow_ctrl

Overview:
- Parametrised successor to the fixed 5-stage hazard/stall controller in the CPU pipeline.
- Tracks one valid bit per stage for NUM_STAGES stages (stage 0 = fetch, NUM_STAGES-1 = writeback/retire).
- Generates per-stage pipeline-register load strobes, memory request gating, PC load/redirect, and branch flush of younger stages.
- New relative to the predecessor: latched completion, so a one-cycle memory response is never lost under downstream backpressure. Also discards an in-flight fetch response after a redirect.

Parameters:
- NUM_STAGES, 5, number of pipeline stages; legal range 3..8.
- FLUSH_STAGE, 2, index of the stage that resolves branches; legal range 1..NUM_STAGES-2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- stage_done_i  in  NUM_STAGES  per-stage work-complete pulse or level (e.g. imem_resp on bit 0, dmem_resp on the mem stage; tie high for single-cycle stages).
- stage_hold_i  in  NUM_STAGES  per-stage hazard hold; stage may not advance while high.
- flush_i  in  1  branch taken/mispredict from FLUSH_STAGE; qualified by that stage advancing.
- stage_valid_o  out  NUM_STAGES  valid_q per stage.
- stage_req_o  out  NUM_STAGES  memory/work request enable = valid_q[s] & ~done_q[s].
- stage_load_o  out  NUM_STAGES  load strobe for the pipeline register after stage s; bit NUM_STAGES-1 is the retire pulse.
- pc_load_o  out  1  load PC (sequential or redirect).
- pc_redirect_o  out  1  PC mux selects branch target this cycle.
- retire_o  out  1  instruction commits (= stage_load_o[NUM_STAGES-1]).

Behaviour:
- Reset (async): valid_q, done_q and discard_q all 0. All outputs are 0 while rst is high and in the first cycle after release.
- Stage 0 valid: valid_q[0] becomes 1 on the first clk edge after reset release and stays 1 thereafter (fetch always outstanding).
- Effective done: edone[s] = stage_done_i[s] | done_q[s].
- Advance: adv[s] = valid_q[s] & edone[s] & ~stage_hold_i[s] & (s==N-1 | ~valid_q[s+1] | adv[s+1]). Evaluated combinationally from s=N-1 downward; no combinational loop, since adv[s+1] depends only on older stages.
- done_q[s]:
  - Set when valid_q[s] & stage_done_i[s] & ~adv[s].
  - Cleared on adv[s] or kill[s].
  - done_q dominates: a duplicate done pulse while latched is ignored.
- valid_q[s] for s>=1:
  - Next = 1 if adv[s-1] & ~kill[s].
  - Else 0 if adv[s] | kill[s].
  - Else hold.
- Flush taken: ft = flush_i & adv[FLUSH_STAGE]. flush_i without adv[FLUSH_STAGE] is ignored; the bench asserts this never happens.
- On ft:
  - kill[s]=1 for 1 <= s <= FLUSH_STAGE. The instruction in FLUSH_STAGE still moves to FLUSH_STAGE+1 normally.
  - stage_load_o[s] forced 0 for s < FLUSH_STAGE.
  - kill[0] clears done_q[0].
- stage_load_o[s] = adv[s] & ~(ft & s<FLUSH_STAGE) & ~(s==0 & discard_q).
- pc_load_o = ft | (adv[0] & ~discard_q). pc_redirect_o = ft.
- Fetch discard:
  - On ft, if stage 0 has an outstanding request (valid_q[0] & ~edone[0]), set discard_q.
  - While discard_q=1, the next stage_done_i[0] is consumed: no load, no PC load, and discard_q clears.
  - stage_req_o[0] stays high during discard (response still awaited).
  - If ft occurs while discard_q=1, discard_q stays set.
- Simultaneous adv[s] and adv[s-1]: valid_q[s] stays 1 (pass-through), no bubble.
- Hold on an older stage propagates backpressure to all younger stages within the same cycle.
- Latency: single-cycle stage with done tied high and no hold passes an instruction in 1 cycle per stage.
- Reset mid-operation: all state clears immediately (async). Outstanding memory responses arriving after release are not tracked; memory is reset alongside.

Decomposition:
- Package pipe_flow_pkg: stage index typedef (logic [$clog2(NUM_STAGES)-1:0]), default constants, stage_vec_t typedef.
- One sub-module, pipe_stage_slot: holds valid_q/done_q for one stage and computes adv from its inputs plus the downstream ready.
- Instantiated NUM_STAGES-1 times via generate; stage 0 logic and discard_q live at top level.

Test Plan (N=5, FLUSH_STAGE=2, done tied 1 on stages 1,2,4 unless stated):
- Reset release, imem done every cycle, no holds:
  - valid goes 00001 then 00011 … 11111 by cycle 5.
  - retire_o first pulses at cycle 5, then every cycle.
  - pc_load_o high every cycle from cycle 1.
- Stage 3 done delayed 4 cycles (dmem latency):
  - stage_load_o[3] low 4 cycles; stages 0..2 frozen (load 0).
  - stage_req_o[3] high until done, then resumes.
- Stage 3 done pulse while stage_hold_i[3]=1 for 3 cycles:
  - done_q[3] latches, stage_req_o[3] drops to 0.
  - Advance occurs the cycle hold drops, with no re-request.
- flush_i with adv[2], stage 0 done same cycle:
  - valid[1..2] cleared next cycle; stage_load_o[0..1]=0.
  - pc_redirect_o=pc_load_o=1; discard_q stays 0.
- flush_i with adv[2], imem done arriving 2 cycles later:
  - discard_q set; late done produces no stage_load_o[0] and no pc_load_o.
  - The following done loads normally.
- Async rst asserted mid-stream between clock edges: all valid and outputs 0 immediately, before the next edge; pipeline refills per first scenario after release.

Source files
------------

// File: rtl/pipe_flow_pkg.sv
// Shared types and defaults for the parametrised pipeline flow controller.
package pipe_flow_pkg;

  localparam int unsigned NUM_STAGES_DEF  = 5;
  localparam int unsigned FLUSH_STAGE_DEF = 2;
  localparam int unsigned MAX_STAGES      = 8;

  typedef logic [$clog2(NUM_STAGES_DEF)-1:0] stage_idx_t;
  typedef logic [MAX_STAGES-1:0]             stage_vec_t;

  // Stages at or younger than the branch-resolving stage are killed on a taken flush.
  function automatic logic in_flush_zone(input int unsigned s, input int unsigned fs);
    return s <= fs;
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_slot.sv
// One pipeline stage slot (stage >= 1): valid/done tracking and advance decision.
module pipe_stage_slot
  import pipe_flow_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic done_i,
  input  logic hold_i,
  input  logic fill_i,
  input  logic kill_i,
  input  logic down_rdy_i,
  output logic valid_o,
  output logic req_o,
  output logic adv_o,
  output logic rdy_o
);

  logic valid_q, valid_d;
  logic done_q, done_d;
  logic edone, adv;

  assign edone = done_i | done_q;
  assign adv   = valid_q & edone & ~hold_i & down_rdy_i;

  always_comb begin
    valid_d = valid_q;
    if (fill_i) begin
      valid_d = 1'b1;
    end else if (adv || kill_i) begin
      valid_d = 1'b0;
    end
    // A latched completion absorbs any further done pulses until the slot drains.
    done_d = done_q;
    if (adv || kill_i) begin
      done_d = 1'b0;
    end else if (valid_q && done_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = valid_q & ~done_q;
  assign adv_o   = adv;
  assign rdy_o   = ~valid_q | adv;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-stage valid tracking, load strobes, PC control,
// branch flush of younger stages and discard of a stale fetch response.
module pipe_flow_ctrl
  import pipe_flow_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = NUM_STAGES_DEF,
  parameter int unsigned FLUSH_STAGE = FLUSH_STAGE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  input  logic [NUM_STAGES-1:0] stage_hold_i,
  input  logic                  flush_i,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [NUM_STAGES-1:0] stage_req_o,
  output logic [NUM_STAGES-1:0] stage_load_o,
  output logic                  pc_load_o,
  output logic                  pc_redirect_o,
  output logic                  retire_o
);

  logic [NUM_STAGES-1:0] valid, req, adv, kill, load;
  logic valid0_q, valid0_d;
  logic done0_q, done0_d;
  logic discard_q, discard_d;
  logic edone0, ft, rdy1;

  assign edone0 = stage_done_i[0] | done0_q;
  assign adv[0] = valid0_q & edone0 & ~stage_hold_i[0] & rdy1;
  assign ft     = flush_i & adv[FLUSH_STAGE];

  always_comb begin
    kill = '0;
    load = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      kill[s] = ft & in_flush_zone(s, FLUSH_STAGE);
      load[s] = adv[s] & ~(ft & (s < FLUSH_STAGE));
    end
    load[0] = load[0] & ~discard_q;
  end

  always_comb begin
    valid0_d = 1'b1;
    done0_d  = done0_q;
    if (adv[0] || kill[0]) begin
      done0_d = 1'b0;
    end else if (valid0_q && stage_done_i[0]) begin
      done0_d = 1'b1;
    end
    // A redirect while the fetch is still outstanding marks its response as stale.
    if (ft) begin
      discard_d = valid0_q & ~edone0;
    end else begin
      discard_d = discard_q & ~adv[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q  <= 1'b0;
      done0_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      valid0_q  <= valid0_d;
      done0_q   <= done0_d;
      discard_q <= discard_d;
    end
  end

  assign valid[0] = valid0_q;
  assign req[0]   = valid0_q & ~done0_q;
  assign rdy1     = g_slot[1].rdy_w;

  // Slots fill from the upstream load strobe (not raw advance) so a discarded
  // fetch never creates a valid entry; the ready chain runs through per-slot
  // nets to keep each link a distinct signal.
  for (genvar s = 1; s < NUM_STAGES; s++) begin : g_slot
    logic rdy_w, down_rdy_w, valid_w, req_w, adv_w;

    if (s == NUM_STAGES - 1) begin : g_tail
      assign down_rdy_w = 1'b1;
    end else begin : g_body
      assign down_rdy_w = g_slot[s+1].rdy_w;
    end

    pipe_stage_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .done_i     (stage_done_i[s]),
      .hold_i     (stage_hold_i[s]),
      .fill_i     (load[s-1]),
      .kill_i     (kill[s]),
      .down_rdy_i (down_rdy_w),
      .valid_o    (valid_w),
      .req_o      (req_w),
      .adv_o      (adv_w),
      .rdy_o      (rdy_w)
    );

    assign valid[s] = valid_w;
    assign req[s]   = req_w;
    assign adv[s]   = adv_w;
  end

  assign stage_valid_o = valid;
  assign stage_req_o   = req;
  assign stage_load_o  = load;
  assign pc_load_o     = ft | (adv[0] & ~discard_q);
  assign pc_redirect_o = ft;
  assign retire_o      = load[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Randomized and directed checks of pipe_flow_ctrl against an occupancy model.
module tb_pipe_flow_ctrl;

  localparam int N  = 5;
  localparam int FS = 2;
  localparam logic [N-1:0] YOUNG_M = 5'b00011;  // stages younger than FS
  localparam logic [N-1:0] KILL_M  = 5'b00111;  // stages whose state a flush clears

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] stage_done_i;
  logic [N-1:0] stage_hold_i;
  logic         flush_i;
  logic [N-1:0] stage_valid_o, stage_req_o, stage_load_o;
  logic         pc_load_o, pc_redirect_o, retire_o;

  int checks = 0;
  int errors = 0;

  pipe_flow_ctrl #(.NUM_STAGES(N), .FLUSH_STAGE(FS)) dut (
    .clk           (clk),
    .rst           (rst),
    .stage_done_i  (stage_done_i),
    .stage_hold_i  (stage_hold_i),
    .flush_i       (flush_i),
    .stage_valid_o (stage_valid_o),
    .stage_req_o   (stage_req_o),
    .stage_load_o  (stage_load_o),
    .pc_load_o     (pc_load_o),
    .pc_redirect_o (pc_redirect_o),
    .retire_o      (retire_o)
  );

  always #5 clk = ~clk;

  // Model: which slots hold an instruction, which have their response in hand,
  // and whether a stale fetch response is still to arrive.
  logic [N-1:0] m_occ, m_got;
  logic         m_disc;
  logic [N-1:0] m_mv, m_load, m_occ_n, m_got_n;
  logic         m_ft, m_pc, m_disc_n, m_room;

  always_comb begin
    m_mv   = '0;
    m_room = 1'b1;
    for (int s = N - 1; s >= 0; s--) begin
      m_mv[s] = m_occ[s] && (stage_done_i[s] || m_got[s]) && !stage_hold_i[s] && m_room;
      m_room  = !m_occ[s] || m_mv[s];
    end
    m_ft     = flush_i & m_mv[FS];
    m_load   = m_mv & ~(m_ft ? YOUNG_M : '0) & ~{{(N-1){1'b0}}, m_disc};
    m_pc     = m_ft | (m_mv[0] & ~m_disc);
    m_occ_n  = (m_occ & ~(m_mv | (m_ft ? KILL_M : '0))) | {m_load[N-2:0], 1'b1};
    m_got_n  = (m_got | (m_occ & stage_done_i)) & ~(m_mv | (m_ft ? KILL_M : '0));
    m_disc_n = m_ft ? (m_occ[0] & ~(stage_done_i[0] | m_got[0])) : (m_disc & ~m_mv[0]);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ  <= '0;
      m_got  <= '0;
      m_disc <= 1'b0;
    end else begin
      m_occ  <= m_occ_n;
      m_got  <= m_got_n;
      m_disc <= m_disc_n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid",    32'(stage_valid_o), 32'(m_occ));
    chk("req",      32'(stage_req_o),   32'(m_occ & ~m_got));
    chk("load",     32'(stage_load_o),  32'(m_load));
    chk("pc_load",  32'(pc_load_o),     32'(m_pc));
    chk("redirect", 32'(pc_redirect_o), 32'(m_ft));
    chk("retire",   32'(retire_o),      32'(m_load[N-1]));
  end

  task automatic step(input logic [N-1:0] d, input logic [N-1:0] h, input logic fr);
    @(posedge clk);
    #2;
    stage_done_i = d;
    stage_hold_i = h;
    flush_i      = 1'b0;
    #1;
    flush_i = fr & m_mv[FS];
    @(negedge clk);
    #1;
  endtask

  task automatic fill_check(input string tag);
    logic [N-1:0] expv;
    for (int i = 1; i <= N; i++) begin
      step('1, '0, 1'b0);
      expv = N'((1 << i) - 1);
      chk({tag, "_valid"},   32'(stage_valid_o), 32'(expv));
      chk({tag, "_pc_load"}, 32'(pc_load_o),     32'd1);
      chk({tag, "_retire"},  32'(retire_o),      32'(i == N));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   32'(stage_valid_o), 32'd0);
    chk({tag, "_req"},     32'(stage_req_o),   32'd0);
    chk({tag, "_load"},    32'(stage_load_o),  32'd0);
    chk({tag, "_pc_load"}, 32'(pc_load_o),     32'd0);
    chk({tag, "_retire"},  32'(retire_o),      32'd0);
  endtask

  task automatic refill;
    for (int i = 0; i < N; i++) step('1, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rd, rh;
    logic         rf;
    rst          = 1'b1;
    stage_done_i = '1;
    stage_hold_i = '0;
    flush_i      = 1'b0;
    #12;
    chk_all_zero("reset");
    #11;
    rst = 1'b0;
    #1;
    chk_all_zero("post_release");
    fill_check("fill");

    // dmem latency on stage 3: upstream freezes, request stays up
    refill();
    for (int i = 0; i < 4; i++) begin
      step(5'b10111, '0, 1'b0);
      chk("dmem_load_low", 32'(stage_load_o[3:0]), 32'd0);
      chk("dmem_req3",     32'(stage_req_o[3]),    32'd1);
    end
    step('1, '0, 1'b0);
    chk("dmem_resume", 32'(stage_load_o[3:0]), 32'hF);

    // completion latched under hold; advance without re-request
    refill();
    step('1, 5'b01000, 1'b0);
    chk("hold_load3_a", 32'(stage_load_o[3]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(5'b10111, 5'b01000, 1'b0);
      chk("hold_req3",  32'(stage_req_o[3]),  32'd0);
      chk("hold_load3", 32'(stage_load_o[3]), 32'd0);
    end
    step(5'b10111, '0, 1'b0);
    chk("hold_release_load3", 32'(stage_load_o[3]), 32'd1);
    chk("hold_release_req3",  32'(stage_req_o[3]),  32'd0);

    // flush with fetch completing the same cycle
    refill();
    step('1, '0, 1'b1);
    chk("fl0_redirect", 32'(pc_redirect_o), 32'd1);
    chk("fl0_pc_load",  32'(pc_load_o),     32'd1);
    chk("fl0_load",     32'(stage_load_o),  32'h1C);
    step('1, '0, 1'b0);
    chk("fl0_valid_after", 32'(stage_valid_o), 32'h19);
    chk("fl0_no_discard",  32'(pc_load_o),     32'd1);
    chk("fl0_load0",       32'(stage_load_o[0]), 32'd1);

    // flush with fetch outstanding: late response is dropped
    refill();
    step(5'b11110, '0, 1'b1);
    chk("fl1_redirect", 32'(pc_redirect_o), 32'd1);
    chk("fl1_pc_load",  32'(pc_load_o),     32'd1);
    chk("fl1_load",     32'(stage_load_o),  32'h1C);
    step(5'b11110, '0, 1'b0);
    chk("fl1_valid_after", 32'(stage_valid_o), 32'h19);
    chk("fl1_req0",        32'(stage_req_o[0]), 32'd1);
    chk("fl1_wait_pc",     32'(pc_load_o),      32'd0);
    step('1, '0, 1'b0);
    chk("fl1_stale_load0", 32'(stage_load_o[0]), 32'd0);
    chk("fl1_stale_pc",    32'(pc_load_o),       32'd0);
    step('1, '0, 1'b0);
    chk("fl1_next_load0", 32'(stage_load_o[0]), 32'd1);
    chk("fl1_next_pc",    32'(pc_load_o),       32'd1);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rd[0] = ($urandom_range(0, 2) != 0);
      rd[1] = ($urandom_range(0, 9) != 0);
      rd[2] = ($urandom_range(0, 9) != 0);
      rd[3] = ($urandom_range(0, 3) == 0);
      rd[4] = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < N; b++) rh[b] = ($urandom_range(0, 9) == 0);
      rf = ($urandom_range(0, 4) == 0);
      step(rd, rh, rf);
    end

    // asynchronous reset between edges
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    stage_done_i = '1;
    stage_hold_i = '0;
    flush_i      = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("async_release");
    fill_check("refill");

    for (int i = 0; i < 500; i++) begin
      rd = N'($urandom);
      rh = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step(rd | 5'b10110, rh, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
